sp_ram: RTL and testbench



---
 rtl/sp_ram_pkg.sv | 20 ++
 rtl/sp_ram_array.sv | 38 +++
 rtl/sp_ram.sv | 62 ++++++
 tb/tb_sp_ram.sv | 133 +++++++++++++
 4 files changed

// File: rtl/sp_ram_pkg.sv
// ============================================================================
// Module      : sp_ram_pkg
// Description : Default geometry shared by the sp_ram top and its storage array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sp_ram_pkg;

    localparam int unsigned C_DEF_DATA_WIDTH = 32;
    localparam int unsigned C_DEF_ADDR_WIDTH = 10;

    // Number of words addressed by an ADDR_WIDTH-bit address.
    function automatic int unsigned depth_of(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage : sp_ram_pkg

`default_nettype wire

// File: rtl/sp_ram_array.sv
// ============================================================================
// Module      : sp_ram_array
// Description : Inferable storage with a synchronous write port and an
//               unregistered read path. It has no reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sp_ram_array
    import sp_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = C_DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = C_DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

    // The declaration initialiser gives power-up or configuration zeros.
    // Reset deliberately does not touch the contents.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule : sp_ram_array

`default_nettype wire

// File: rtl/sp_ram.sv
// ============================================================================
// Module      : sp_ram
// Description : Single-port synchronous RAM with a registered, write-first
//               read port and an asynchronous active-low output reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sp_ram
    import sp_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = C_DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = C_DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    output logic [DATA_WIDTH-1:0] q
);

    logic                  array_we;
    logic [DATA_WIDTH-1:0] array_rdata;
    logic [DATA_WIDTH-1:0] q_d;
    logic [DATA_WIDTH-1:0] q_q;

    // An edge that lands while rst_n is low must not write.
    assign array_we = we & rst_n;

    sp_ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .we_i    (array_we),
        .addr_i  (addr),
        .wdata_i (data),
        .rdata_o (array_rdata)
    );

    // Write-first: a write presents the new data, never the old contents.
    always_comb begin
        q_d = array_rdata;
        if (we) begin
            q_d = data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : sp_ram

`default_nettype wire

// File: tb/tb_sp_ram.sv
// ============================================================================
// Module      : tb_sp_ram
// Description : Directed self-checking bench for sp_ram using immediate
//               assertions and hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sp_ram;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 10;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] q;

    int checks = 0;
    int errors = 0;

    sp_ram #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (data),
        .addr  (addr),
        .we    (we),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive the inputs, then wait one full cycle so the
    // rising edge in between has been taken and q is stable.
    task automatic cyc(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we   = w;
        addr = a;
        data = d;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        we    = 1'b0;
        addr  = '0;
        data  = '0;
        #2;
        check("reset_q", q, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Unwritten location after power-up.
        cyc(1'b0, 10'd77, 32'h0);
        check("unwritten_77", q, 32'h0);

        // Write-first with we held high.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 10'd0, 32'hAAAA_AAAA);
            check("write_first_aaaa", q, 32'hAAAA_AAAA);
        end

        // Overwrite, then plain reads of the new value.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 10'd0, 32'h1111_1111);
            check("overwrite_1111", q, 32'h1111_1111);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 10'd0, 32'hFFFF_FFFF);
            check("read_after_overwrite", q, 32'h1111_1111);
        end

        // Address extremes, no aliasing between 0 and 1023.
        cyc(1'b1, 10'd1023, 32'hDEAD_BEEF);
        check("write_1023", q, 32'hDEAD_BEEF);
        cyc(1'b1, 10'd0, 32'h0000_0001);
        check("write_0", q, 32'h0000_0001);
        cyc(1'b0, 10'd1023, 32'h0);
        check("read_1023", q, 32'hDEAD_BEEF);
        cyc(1'b0, 10'd0, 32'h0);
        check("read_0", q, 32'h0000_0001);

        // Reset in the middle of operation, with a write attempted during it.
        cyc(1'b1, 10'd5, 32'h1234_5678);
        check("write_5", q, 32'h1234_5678);
        #2;
        rst_n = 1'b0;
        we    = 1'b1;
        data  = 32'h0;
        addr  = 10'd5;
        #1;
        check("async_reset_q", q, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("q_held_in_reset", q, 32'h0);
        we    = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("read_5_after_reset", q, 32'h1234_5678);

        // Back-to-back writes then reads with one cycle of latency.
        for (int a = 1; a <= 8; a++) begin
            cyc(1'b1, AW'(a), DW'(32'h100 + a));
            check("b2b_write", q, DW'(32'h100 + a));
        end
        for (int a = 1; a <= 8; a++) begin
            cyc(1'b0, AW'(a), 32'h0);
            check("b2b_read", q, DW'(32'h100 + a));
        end
        cyc(1'b0, 10'd77, 32'h0);
        check("unwritten_77_again", q, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sp_ram

`default_nettype wire
